// File: rtl/rgb_pwm_array.sv
// Multi-channel PWM peripheral: one shared prescaled period counter drives CHANNELS
// comparators; duty values are double-buffered and can optionally fade one LSB per period.
module rgb_pwm_array #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int ADDR_W   = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                WR_EN,
    input  logic [ADDR_W-1:0]   WR_ADDR,
    input  logic [WIDTH-1:0]    WR_DATA,
    input  logic                WR_FADE,
    output logic [CHANNELS-1:0] LED_OUT,
    output logic                PERIOD_START,
    output logic [CHANNELS-1:0] BUSY
);

    localparam int               PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    // The counter stops one short of all-ones so a full-scale duty is never compared false.
    localparam logic [WIDTH-1:0] CNT_LAST = {WIDTH{1'b1}} - WIDTH'(1);

    logic [PS_W-1:0]  presc_reg;
    logic [PS_W-1:0]  presc_next;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic             period_start_reg;
    logic             period_start_next;
    logic             tick;
    logic             boundary;

    assign tick     = (presc_reg == PS_LAST);
    assign boundary = tick && (cnt_reg == CNT_LAST);

    always_comb begin
        presc_next = presc_reg + PS_W'(1);
        if (tick) begin
            presc_next = '0;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (tick) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt_reg + WIDTH'(1);
            end
        end
    end

    // Pulse only on the first prescaler cycle of CNT=0, so it stays one CLK wide.
    assign period_start_next = (cnt_reg == '0) && (presc_reg == '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_reg        <= '0;
            cnt_reg          <= '0;
            period_start_reg <= 1'b0;
        end else begin
            presc_reg        <= presc_next;
            cnt_reg          <= cnt_next;
            period_start_reg <= period_start_next;
        end
    end

    assign PERIOD_START = period_start_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [WIDTH-1:0] target_reg;
            logic [WIDTH-1:0] target_next;
            logic [WIDTH-1:0] active_reg;
            logic [WIDTH-1:0] active_next;
            logic             fade_reg;
            logic             fade_next;
            logic             led_reg;
            logic             busy_reg;
            logic             wr_hit;

            // Out-of-range addresses match no channel and are dropped here.
            assign wr_hit = WR_EN && (WR_ADDR == ADDR_W'(gi));

            always_comb begin
                target_next = target_reg;
                fade_next   = fade_reg;
                if (wr_hit) begin
                    target_next = WR_DATA;
                    fade_next   = WR_FADE;
                end
            end

            // Boundary update reads the pre-write target, so a same-edge write waits a period.
            always_comb begin
                active_next = active_reg;
                if (boundary) begin
                    if (!fade_reg) begin
                        active_next = target_reg;
                    end else if (active_reg < target_reg) begin
                        active_next = active_reg + WIDTH'(1);
                    end else if (active_reg > target_reg) begin
                        active_next = active_reg - WIDTH'(1);
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    target_reg <= '0;
                    active_reg <= '0;
                    fade_reg   <= 1'b0;
                    led_reg    <= 1'b0;
                    busy_reg   <= 1'b0;
                end else begin
                    target_reg <= target_next;
                    active_reg <= active_next;
                    fade_reg   <= fade_next;
                    led_reg    <= (cnt_reg < active_reg);
                    busy_reg   <= (active_next != target_next);
                end
            end

            assign LED_OUT[gi] = led_reg;
            assign BUSY[gi]    = busy_reg;
        end
    endgenerate

endmodule

// File: tb/tb_rgb_pwm_array.sv
// Bench for rgb_pwm_array: two configurations (8-bit/prescale 1 and 4-bit/prescale 4)
// checked every cycle against a period-arithmetic model, plus directed high-count checks.
module tb_rgb_pwm_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v     [2];
    logic       wr_en_v   [2];
    logic [3:0] wr_addr_v [2];
    logic [7:0] wr_data_v [2];
    logic       wr_fade_v [2];

    logic [2:0] led_a, led_b, busy_a, busy_b;
    logic       ps_a, ps_b;

    rgb_pwm_array #(.CHANNELS(3), .WIDTH(8), .PRESCALE(1), .ADDR_W(4)) dut_a (
        .CLK(clk), .RST(rst_v[0]), .WR_EN(wr_en_v[0]), .WR_ADDR(wr_addr_v[0]),
        .WR_DATA(wr_data_v[0]), .WR_FADE(wr_fade_v[0]),
        .LED_OUT(led_a), .PERIOD_START(ps_a), .BUSY(busy_a)
    );

    rgb_pwm_array #(.CHANNELS(3), .WIDTH(4), .PRESCALE(4), .ADDR_W(4)) dut_b (
        .CLK(clk), .RST(rst_v[1]), .WR_EN(wr_en_v[1]), .WR_ADDR(wr_addr_v[1]),
        .WR_DATA(wr_data_v[1][3:0]), .WR_FADE(wr_fade_v[1]),
        .LED_OUT(led_b), .PERIOD_START(ps_b), .BUSY(busy_b)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    function automatic int ticks_of(input int i);   // ticks per period = 2^WIDTH-1
        return (i == 0) ? 255 : 15;
    endfunction
    function automatic int pre_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction
    function automatic int period_of(input int i);
        return ticks_of(i) * pre_of(i);
    endfunction
    function automatic logic [2:0] led_of(input int i);
        return (i == 0) ? led_a : led_b;
    endfunction
    function automatic logic [2:0] busy_of(input int i);
        return (i == 0) ? busy_a : busy_b;
    endfunction
    function automatic logic ps_of(input int i);
        return (i == 0) ? ps_a : ps_b;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: n = CLK edges since reset; the position inside the period is n mod period,
    // the tick index is that divided by the prescale; active duty changes once per period.
    int         m_n   [2];
    int         m_tgt [2][3];
    int         m_act [2][3];
    bit         m_fd  [2][3];
    logic [2:0] exp_led  [2];
    logic [2:0] exp_busy [2];
    logic       exp_ps   [2];

    initial begin : model
        int pos;
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; exp_led[i] = '0; exp_busy[i] = '0; exp_ps[i] = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_tgt[i][c] = 0; m_act[i][c] = 0; m_fd[i][c] = 1'b0;
            end
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst_v[i]) begin
                    m_n[i] = 0; exp_led[i] = '0; exp_busy[i] = '0; exp_ps[i] = 1'b0;
                    for (int c = 0; c < 3; c++) begin
                        m_tgt[i][c] = 0; m_act[i][c] = 0; m_fd[i][c] = 1'b0;
                    end
                end else begin
                    pos = m_n[i] % period_of(i);
                    exp_ps[i] = (pos == 0);
                    for (int c = 0; c < 3; c++)
                        exp_led[i][c] = ((pos / pre_of(i)) < m_act[i][c]);
                    if (((m_n[i] + 1) % period_of(i)) == 0) begin
                        for (int c = 0; c < 3; c++) begin
                            if (!m_fd[i][c])                   m_act[i][c] = m_tgt[i][c];
                            else if (m_act[i][c] < m_tgt[i][c]) m_act[i][c]++;
                            else if (m_act[i][c] > m_tgt[i][c]) m_act[i][c]--;
                        end
                    end
                    if (wr_en_v[i] && (int'(wr_addr_v[i]) < 3)) begin
                        m_tgt[i][wr_addr_v[i]] = int'(wr_data_v[i]) & ticks_of(i);
                        m_fd[i][wr_addr_v[i]]  = wr_fade_v[i];
                    end
                    for (int c = 0; c < 3; c++)
                        exp_busy[i][c] = (m_act[i][c] != m_tgt[i][c]);
                    m_n[i]++;
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < 2; i++) begin
                    vectors++;
                    if ({led_of(i), ps_of(i), busy_of(i)} !== {exp_led[i], exp_ps[i], exp_busy[i]}) begin
                        miscompares++;
                        $display("FAIL cycle_i%0d: led/ps/busy got %b/%b/%b, required %b/%b/%b (t=%0t)",
                                 i, led_of(i), ps_of(i), busy_of(i),
                                 exp_led[i], exp_ps[i], exp_busy[i], $time);
                    end
                end
            end
        end
    end

    task automatic do_write(input int inst, input int ch, input int d, input bit f);
        @(negedge clk);
        wr_en_v[inst] = 1'b1; wr_addr_v[inst] = 4'(ch); wr_data_v[inst] = 8'(d); wr_fade_v[inst] = f;
        @(negedge clk);
        wr_en_v[inst] = 1'b0;
    endtask

    task automatic wait_ps(input int inst);
        for (int k = 0; k < 2 * period_of(inst) + 10; k++) begin
            @(negedge clk);
            if (ps_of(inst)) return;
        end
        check($sformatf("wait_ps_timeout_i%0d", inst), 0, 1);
    endtask

    // Starts on a PERIOD_START cycle, counts high cycles per channel over one period,
    // optionally issuing a one-cycle write at offset wr_k; ends on the next period's first cycle.
    task automatic count_period(input int inst, input int wr_k, input int wr_ch, input int wr_d,
                                input bit wr_f, output int h0, output int h1, output int h2,
                                output logic [2:0] busy0);
        logic [2:0] l;
        h0 = 0; h1 = 0; h2 = 0;
        check($sformatf("ps_at_period_start_i%0d", inst), int'(ps_of(inst)), 1);
        busy0 = busy_of(inst);
        for (int k = 0; k < period_of(inst); k++) begin
            l = led_of(inst);
            h0 += int'(l[0]); h1 += int'(l[1]); h2 += int'(l[2]);
            wr_en_v[inst]   = (k == wr_k);
            wr_addr_v[inst] = 4'(wr_ch);
            wr_data_v[inst] = 8'(wr_d);
            wr_fade_v[inst] = wr_f;
            @(negedge clk);
        end
        wr_en_v[inst] = 1'b0;
    endtask

    initial begin : stimulus
        int h0, h1, h2;
        logic [2:0] b0;
        int sel;
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; wr_en_v[i] = 1'b0; wr_addr_v[i] = '0; wr_data_v[i] = '0; wr_fade_v[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_led_a", int'(led_a), 0);
        check("reset_busy_a", int'(busy_a), 0);
        check("reset_ps_a", int'(ps_a), 0);
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;

        // Half duty on ch0, other channels untouched.
        do_write(0, 0, 128, 1'b0);
        wait_ps(0);
        check("ch0_high_on_ps_cycle", int'(led_a[0]), 1);
        count_period(0, -1, 0, 0, 1'b0, h0, h1, h2, b0);
        check("ch0_duty128_highs", h0, 128);
        check("ch1_idle_highs", h1, 0);

        // Extremes: constant low and constant high across three periods.
        do_write(0, 1, 0, 1'b0);
        do_write(0, 2, 255, 1'b0);
        wait_ps(0);
        for (int p = 0; p < 3; p++) begin
            count_period(0, -1, 0, 0, 1'b0, h0, h1, h2, b0);
            check("ch1_duty0_highs", h1, 0);
            check("ch2_duty255_highs", h2, 255);
        end

        // Double buffering: mid-period write, then a write landing on the boundary edge.
        do_write(0, 0, 10, 1'b0);
        wait_ps(0);
        count_period(0, 50, 0, 200, 1'b0, h0, h1, h2, b0);
        check("midperiod_write_keeps_old", h0, 10);
        count_period(0, period_of(0) - 2, 0, 30, 1'b0, h0, h1, h2, b0);
        check("new_duty_next_period", h0, 200);
        count_period(0, -1, 0, 0, 1'b0, h0, h1, h2, b0);
        check("boundary_write_deferred", h0, 200);
        count_period(0, -1, 0, 0, 1'b0, h0, h1, h2, b0);
        check("boundary_write_applied", h0, 30);

        // Fade up 0 -> 4 and back down.
        do_write(0, 0, 0, 1'b0);
        wait_ps(0);
        count_period(0, 10, 0, 4, 1'b1, h0, h1, h2, b0);
        check("fade_start_zero", h0, 0);
        for (int j = 1; j <= 4; j++) begin
            count_period(0, -1, 0, 0, 1'b0, h0, h1, h2, b0);
            check($sformatf("fade_up_step%0d", j), h0, j);
            check($sformatf("fade_up_busy%0d", j), int'(b0[0]), (j < 4) ? 1 : 0);
        end
        count_period(0, 10, 0, 0, 1'b1, h0, h1, h2, b0);
        check("fade_steady", h0, 4);
        for (int j = 1; j <= 4; j++) begin
            count_period(0, -1, 0, 0, 1'b0, h0, h1, h2, b0);
            check($sformatf("fade_down_step%0d", j), h0, 4 - j);
            check($sformatf("fade_down_busy%0d", j), int'(b0[0]), (j < 4) ? 1 : 0);
        end

        // Reset in mid-period.
        do_write(0, 0, 200, 1'b0);
        wait_ps(0);
        repeat (100) @(negedge clk);
        rst_v[0] = 1'b1;
        @(negedge clk);
        check("midreset_led", int'(led_a), 0);
        check("midreset_busy", int'(busy_a), 0);
        rst_v[0] = 1'b0;
        wait_ps(0);
        count_period(0, -1, 0, 0, 1'b0, h0, h1, h2, b0);
        check("after_reset_ch0_low", h0, 0);
        check("after_reset_ch2_low", h2, 0);

        // Randomized traffic on both instances, including stray addresses and resets.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                rst_v[i]     = ($urandom_range(0, 599) == 0);
                wr_en_v[i]   = ($urandom_range(0, 7) == 0);
                wr_addr_v[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
                sel = int'($urandom_range(0, 4));
                wr_data_v[i] = (sel == 0) ? 8'd0 : (sel == 1) ? 8'hFF : (sel == 2) ? 8'd1 : 8'($urandom);
                wr_fade_v[i] = 1'($urandom_range(0, 1));
            end
        end
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b0; wr_en_v[i] = 1'b0;
        end

        // 4-bit, prescale-4 instance: 60-cycle period, duty 5 = 20 CLK high.
        rst_v[1] = 1'b1;
        @(negedge clk);
        rst_v[1] = 1'b0;
        do_write(1, 0, 5, 1'b0);
        wait_ps(1);
        count_period(1, 7, 3, 15, 1'b1, h0, h1, h2, b0);
        check("b_duty5_highs", h0, 20);
        check("b_stray_write_busy", int'(busy_b), 0);
        count_period(1, -1, 0, 0, 1'b0, h0, h1, h2, b0);
        check("b_duty5_highs_again", h0, 20);
        check("b_ch1_after_stray", h1, 0);
        check("b_ch2_after_stray", h2, 0);
        check("b_period60_ps", int'(ps_b), 1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_array.md
Name: rgb_pwm_array

Overview:
Parametrised multi-channel PWM peripheral, successor to the single-channel 8-bit LED duty generator. Drives CHANNELS LED outputs (default 3 = R,G,B) from one shared period counter. Duty registers are double-buffered and written via a simple addressed write port from the MCU I/O bus. Each channel also has an optional linear fade mode.

Parameters:
CHANNELS, 3, number of PWM outputs (1..16)
WIDTH, 8, duty resolution in bits; period = 2^WIDTH-1 ticks
PRESCALE, 1, CLK cycles per PWM tick (>=1)
ADDR_W, 4, write-address width; must satisfy 2^ADDR_W >= CHANNELS

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
WR_EN  input  1  write strobe, one-cycle qualified
WR_ADDR  input  ADDR_W  channel index for write
WR_DATA  input  WIDTH  target duty value
WR_FADE  input  1  fade-mode bit written with WR_DATA
LED_OUT  output  CHANNELS  registered PWM outputs, bit i = channel i
PERIOD_START  output  1  one-CLK pulse on the first tick of each period
BUSY  output  CHANNELS  bit i high while channel i active duty != target

Behaviour:
- Reset (RST high at a CLK edge): prescaler=0, tick counter CNT=0, all target/active duty=0, fade bits=0, LED_OUT=0, PERIOD_START=0, BUSY=0. Reset has priority over a simultaneous write. RST asserted mid-period aborts the period; the first period after reset starts at CNT=0.
- Prescaler: counts 0..PRESCALE-1; tick asserted when it equals PRESCALE-1. PRESCALE=1 -> tick every cycle.
- CNT: WIDTH bits, advances on tick, range 0..2^WIDTH-2, wraps to 0 (never reaches 2^WIDTH-1). Period = (2^WIDTH-1)*PRESCALE CLK cycles.
- Write: WR_EN=1 and WR_ADDR<CHANNELS -> target[WR_ADDR]<=WR_DATA, fade[WR_ADDR]<=WR_FADE at that edge. WR_ADDR>=CHANNELS -> ignored, no state change. Writes never alter active duty directly.
- Period boundary: the tick on which CNT wraps from 2^WIDTH-2 to 0, per channel:
  fade=0 -> active<=target;
  fade=1 -> active moves one LSB toward target (+1 if below, -1 if above, unchanged if equal).
  A write landing on the same edge as the boundary updates target only; the boundary uses the old target, and the new value applies at the next boundary.
- Compare: pwm_i = (CNT < active_i). Duty 0 -> constantly low. Duty 2^WIDTH-1 -> constantly high. Duty D -> exactly D high ticks per period, starting at CNT=0.
- LED_OUT registered: one-CLK latency from the CNT value to the pin.
- PERIOD_START: high for exactly one CLK, aligned with the LED_OUT cycle that reflects CNT=0 (i.e. the same one-cycle latency).
- BUSY_i = (active_i != target_i), registered. It is 1 from the cycle after a differing write until the boundary at which active reaches target.
- Widths: no overflow possible. Fade saturates at the target and never over- or under-steps past 0 or 2^WIDTH-1.

Test Plan:
- Defaults, RST then write ch0=128 (fade=0): after the next boundary, LED_OUT[0] is high for 128 of every 255 cycles and starts high on the PERIOD_START cycle. Ch1/ch2 stay 0.
- Write ch1=0 and ch2=255: LED_OUT[1] is constant 0 and LED_OUT[2] is constant 1 across three full periods, with no glitch at the wrap.
- Write ch0=200 at CNT=50 while active=10: the current period keeps 10 high ticks; the next period has 200. Same-edge write at the boundary: applied one period later.
- Fade: active=0, write ch0=4 fade=1 -> high counts per period 1,2,3,4, then steady. BUSY[0] drops after the 4th boundary. Reverse 4->0 steps 3,2,1,0.
- PRESCALE=4, WIDTH=4: period = 60 CLK cycles. Duty 5 -> 20 CLK high. WR_ADDR=3 (CHANNELS=3) -> no effect on any output.
- RST asserted at CNT=100 with ch0 active=200: next cycle LED_OUT=0, BUSY=0. After release, output stays low until a new write plus a boundary.
